// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter that sequences chip enables, wait states and read return.
// Define ADDR_ERR_EN to make address region 2'b11 unmapped (err pulse, no chip enable).
module mem_bus_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic          we0,
    input  logic          we1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] bus_addr,
    output logic          bus_we,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic          memce0,
    output logic          memce1,
    output logic          cs,
    output logic          busy,
    output logic          err
);

`ifdef ADDR_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    localparam int unsigned   CW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CntLast = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {StIdle, StGrant, StAccess, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          win_q, win_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [2:0]    ce_q, ce_d;  // {cs, memce1, memce0}
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          pick;
    logic [AW-1:0] pick_addr;
    logic          unmapped;
    logic          finish;

    function automatic logic [2:0] decode(input logic [1:0] region);
        case (region)
            2'b00:   decode = 3'b001;
            2'b01:   decode = 3'b010;
            2'b10:   decode = 3'b100;
            default: decode = ErrEn ? 3'b000 : 3'b100;
        endcase
    endfunction

    always_comb begin
        // On a tie the requester that did not win last time gets the bus.
        pick      = (req0 && req1) ? ~last_q : req1;
        pick_addr = pick ? addr1 : addr0;
        unmapped  = ErrEn && (addr_q[AW-1:AW-2] == 2'b11);
        finish    = 1'b0;

        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        err_d   = 1'b0;
        ce_d    = ce_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StGrant;
                    win_d   = pick;
                    last_d  = pick;
                    addr_d  = pick_addr;
                    we_d    = pick ? we1 : we0;
                    wdata_d = pick ? wdata1 : wdata0;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    ce_d    = decode(pick_addr[AW-1:AW-2]);
                end
            end
            StGrant: begin
                cnt_d = '0;
                if (unmapped) begin
                    state_d = StDone;
                    done_d  = {win_q, ~win_q};
                    err_d   = 1'b1;
                end else if (WAIT_CYCLES == 0) begin
                    finish = 1'b1;
                end else begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == CntLast) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Last wait cycle: drop the chip enable and capture the target's read data.
        if (finish) begin
            state_d = StDone;
            ce_d    = 3'b000;
            done_d  = {win_q, ~win_q};
            if (!we_q) begin
                rdata_d = bus_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            ce_q    <= 3'b000;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ce_q    <= ce_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt0      = gnt_q[0];
    assign gnt1      = gnt_q[1];
    assign done0     = done_q[0];
    assign done1     = done_q[1];
    assign memce0    = ce_q[0];
    assign memce1    = ce_q[1];
    assign cs        = ce_q[2];
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign bus_addr  = addr_q;
    assign bus_we    = we_q;
    assign bus_wdata = wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic and resets.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    parameter int unsigned WAIT = 2;
    localparam int W = int'(WAIT);

`ifdef ADDR_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic [DW-1:0] bus_rdata = '0;
    logic          gnt0, gnt1, done0, done1, memce0, memce1, cs, busy, err, bus_we;
    logic [DW-1:0] rdata, bus_wdata;
    logic [AW-1:0] bus_addr;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .memce0(memce0), .memce1(memce1), .cs(cs),
        .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a transaction is described by its phase, the number of cycles since
    // the grant edge (0 = idle). Every output follows from the phase and the latched request.
    int            m_phase = 0;
    int            m_len   = 0;
    bit            m_last  = 1'b1;
    bit            m_win   = 1'b0;
    bit            m_we    = 1'b0;
    bit            m_unm   = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;

    task automatic model_reset();
        m_phase = 0; m_len = 0; m_last = 1'b1; m_win = 1'b0; m_we = 1'b0; m_unm = 1'b0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        if (m_phase == 0) begin
            if (req0 || req1) begin
                m_win   = (req0 && req1) ? !m_last : req1;
                m_last  = m_win;
                m_addr  = m_win ? addr1 : addr0;
                m_we    = m_win ? we1 : we0;
                m_wdata = m_win ? wdata1 : wdata0;
                m_unm   = ErrEn && (m_addr[AW-1 -: 2] == 2'b11);
                m_len   = m_unm ? 2 : 2 + W;
                m_phase = 1;
            end
        end else if (m_phase == m_len) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == m_len && !m_we && !m_unm) m_rdata = bus_rdata;
        end
    endtask

    task automatic compare_all();
        bit         on;
        bit         dn;
        logic [1:0] r;
        on = (m_phase >= 1) && (m_phase <= 1 + W) && !m_unm;
        dn = (m_phase != 0) && (m_phase == m_len);
        r  = m_addr[AW-1 -: 2];
        chk("gnt0", gnt0, (m_phase == 1) && !m_win);
        chk("gnt1", gnt1, (m_phase == 1) && m_win);
        chk("done0", done0, dn && !m_win);
        chk("done1", done1, dn && m_win);
        chk("memce0", memce0, on && (r == 2'd0));
        chk("memce1", memce1, on && (r == 2'd1));
        chk("cs", cs, on && (r >= 2'd2));
        chk("busy", busy, m_phase != 0);
        chk("err", err, dn && m_unm);
        chk("rdata", rdata, m_rdata);
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_we", bus_we, m_we);
        chk("bus_wdata", bus_wdata, m_wdata);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_all();
    end

    task automatic run_one(input bit who, input logic [AW-1:0] a, input bit w,
                           input logic [DW-1:0] d, output int gnt_at, output int done_at,
                           output int ce_cnt, output int err_cnt, output int bad_hold);
        gnt_at = -1; done_at = -1; ce_cnt = 0; err_cnt = 0; bad_hold = 0;
        @(negedge clk);
        if (who) begin req1 = 1'b1; addr1 = a; we1 = w; wdata1 = d; end
        else begin req0 = 1'b1; addr0 = a; we0 = w; wdata0 = d; end
        for (int n = 1; n <= 20 && done_at < 0; n++) begin
            @(negedge clk);
            if ((who ? gnt1 : gnt0) && gnt_at < 0) gnt_at = n;
            if (memce0 || memce1 || cs) begin
                ce_cnt++;
                if (bus_we !== w || bus_wdata !== d || bus_addr !== a) bad_hold++;
            end
            if (err) err_cnt++;
            if (who ? done1 : done0) begin
                done_at = n;
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, busy, 1'b0);
    endtask

    int ga, da, cc, ec, bh;
    int order[4];
    int n_g, seen, first;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_done", {done1, done0}, 2'b00);
        chk("rst_ce", {cs, memce1, memce0}, 3'b000);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        rst_n = 1'b1;

        // Single read from requester 0.
        bus_rdata = 32'hA5A5_A5A5;
        run_one(1'b0, 32'h0000_0010, 1'b0, 32'h0, ga, da, cc, ec, bh);
        chk("t1_gnt_cycle", ga, 1);
        chk("t1_done_cycle", da, 2 + W);
        chk("t1_ce_cycles", cc, 1 + W);
        chk("t1_rdata", rdata, 32'hA5A5_A5A5);

        // Write from requester 1: bus fields stable while memce0 is up, rdata untouched.
        bus_rdata = 32'h5555_0000;
        run_one(1'b1, 32'h0000_0004, 1'b1, 32'hDEAD_BEEF, ga, da, cc, ec, bh);
        chk("t3_gnt_cycle", ga, 1);
        chk("t3_done_cycle", da, 2 + W);
        chk("t3_ce_cycles", cc, 1 + W);
        chk("t3_hold_errors", bh, 0);
        chk("t3_rdata", rdata, 32'hA5A5_A5A5);

        // Region 2'b11: unmapped with the error option, aliased to cs otherwise.
        bus_rdata = 32'h1234_5678;
        run_one(1'b0, 32'hC000_0000, 1'b0, 32'h0, ga, da, cc, ec, bh);
        chk("t5_done_cycle", da, ErrEn ? 2 : 2 + W);
        chk("t5_err_cycles", ec, ErrEn ? 1 : 0);
        chk("t5_ce_cycles", cc, ErrEn ? 0 : 1 + W);
        chk("t5_rdata", rdata, ErrEn ? 32'hA5A5_A5A5 : 32'h1234_5678);

        // Both requesting from reset: strict alternation starting with requester 0.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        req0 = 1'b1; addr0 = 32'h4000_0000; we0 = 1'b0;
        req1 = 1'b1; addr1 = 32'h8000_0000; we1 = 1'b0;
        n_g = 0;
        for (int n = 0; n < 100 && n_g < 4; n++) begin
            @(negedge clk);
            if (gnt0 && n_g < 4) begin order[n_g] = 0; n_g++; chk("t2_memce1", memce1, 1'b1); end
            if (gnt1 && n_g < 4) begin order[n_g] = 1; n_g++; chk("t2_cs", cs, 1'b1); end
        end
        chk("t2_grants", n_g, 4);
        for (int i = 0; i < 4; i++) chk("t2_order", order[i], i % 2);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle("t2_idle");

        // Reset mid-transaction: everything drops at once, no done, pointer restored.
        @(negedge clk); req0 = 1'b1; addr0 = 32'h0; we0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b0;
        chk("t4_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t4_busy", busy, 1'b0);
        chk("t4_ce", {cs, memce1, memce0}, 3'b000);
        chk("t4_gnt", {gnt1, gnt0}, 2'b00);
        chk("t4_done", {done1, done0}, 2'b00);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0 || done1) seen++;
        end
        chk("t4_no_done", seen, 0);
        req0 = 1'b1; req1 = 1'b1; addr1 = 32'h0;
        first = -1;
        for (int n = 0; n < 10 && first < 0; n++) begin
            @(negedge clk);
            if (gnt0) first = 0;
            else if (gnt1) first = 1;
        end
        chk("t4_first_winner", first, 0);
        req0 = 1'b0; req1 = 1'b0;
        wait_idle("t4_idle");

        // Random traffic, including dropped requests and occasional resets.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 149) != 0);
            req0      = ($urandom_range(0, 3) != 0);
            req1      = ($urandom_range(0, 2) != 0);
            addr0     = $urandom;
            addr1     = $urandom;
            we0       = $urandom_range(0, 1);
            we1       = $urandom_range(0, 1);
            wdata0    = $urandom;
            wdata1    = $urandom;
            bus_rdata = $urandom;
        end
        @(negedge clk);
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        wait_idle("rand_idle");
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
